// File: rtl/pixel_fifo_mixer.sv
// Background pixel FIFO with an 8-entry sprite overlay and palette mixer.
// Head is position 0; every head removal shifts FIFO and overlay together.
module pixel_fifo_mixer #(
    parameter int DEPTH   = 16,
    parameter bit OBJ_ENA = 1'b1,
    localparam int CW     = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          bg_load,
    input  logic [7:0]    bg_hi,
    input  logic [7:0]    bg_lo,
    output logic          bg_ready,
    input  logic          discard_load,
    input  logic [2:0]    discard,
    input  logic          pop,
    output logic          pix_valid,
    output logic [1:0]    color,
    input  logic          obj_load,
    input  logic [7:0]    obj_hi,
    input  logic [7:0]    obj_lo,
    input  logic          obj_pal,
    input  logic          obj_prio,
    input  logic          bg_ena,
    input  logic [7:0]    bgp,
    input  logic [7:0]    obp0,
    input  logic [7:0]    obp1,
    output logic [CW-1:0] count,
    output logic          ovf
);

    typedef struct packed {
        logic [1:0] idx;
        logic       pal;
        logic       prio;
    } obj_t;

    logic [1:0]    r_pix [DEPTH];
    logic [1:0]    w_pix [DEPTH];
    obj_t          r_obj [8];
    obj_t          w_obj [8];
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count;
    logic [CW-1:0] w_base;
    logic [CW-1:0] w_wr;
    logic [2:0]    r_disc;
    logic [2:0]    w_disc;
    logic          r_ovf;
    logic          w_ovf;

    logic          w_has;
    logic          w_valid;
    logic          w_drop;
    logic          w_rem;
    logic          w_ready;
    logic          w_acc;
    logic          w_oload;

    assign w_has   = (r_count != '0);
    assign w_valid = w_has && (r_disc == 3'd0);
    assign w_drop  = w_has && (r_disc != 3'd0);
    assign w_rem   = w_drop || (pop && w_valid);
    assign w_ready = (r_count <= CW'(DEPTH - 8));
    assign w_acc   = bg_load && w_ready;
    assign w_oload = OBJ_ENA && obj_load;

    // Removal shifts first; the new row lands behind whatever survives.
    always_comb begin
        w_base = r_count - {{(CW-1){1'b0}}, w_rem};
        w_wr   = '0;
        for (int i = 0; i < DEPTH - 1; i++) begin
            w_pix[i] = w_rem ? r_pix[i+1] : r_pix[i];
        end
        w_pix[DEPTH-1] = w_rem ? 2'b00 : r_pix[DEPTH-1];
        if (w_acc) begin
            for (int j = 0; j < 8; j++) begin
                w_wr        = w_base + CW'(j);
                w_pix[w_wr] = {bg_hi[7-j], bg_lo[7-j]};
            end
        end
        w_count = w_acc ? (w_base + CW'(8)) : w_base;
    end

    always_comb begin
        w_disc = r_disc;
        if (w_drop) begin
            w_disc = r_disc - 3'd1;
        end
        if (discard_load) begin
            w_disc = discard;
        end
        w_ovf = r_ovf || (bg_load && !w_ready);
    end

    // Merge only into transparent slots so the earlier sprite keeps priority.
    always_comb begin
        for (int i = 0; i < 7; i++) begin
            w_obj[i] = w_rem ? r_obj[i+1] : r_obj[i];
        end
        w_obj[7] = w_rem ? obj_t'('0) : r_obj[7];
        if (w_oload) begin
            for (int i = 0; i < 8; i++) begin
                if (w_obj[i].idx == 2'b00) begin
                    w_obj[i].idx  = {obj_hi[7-i], obj_lo[7-i]};
                    w_obj[i].pal  = obj_pal;
                    w_obj[i].prio = obj_prio;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            r_count <= '0;
            r_disc  <= '0;
            r_ovf   <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                r_obj[i] <= '0;
            end
        end else begin
            r_count <= w_count;
            r_disc  <= w_disc;
            r_ovf   <= w_ovf;
            for (int i = 0; i < 8; i++) begin
                r_obj[i] <= w_obj[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            r_pix[i] <= w_pix[i];
        end
    end

    logic [1:0] w_bgi;
    logic       w_osel;
    logic [7:0] w_opal;
    logic [7:0] w_osh;
    logic [7:0] w_bsh;

    assign w_bgi  = bg_ena ? r_pix[0] : 2'b00;
    assign w_osel = OBJ_ENA && (r_obj[0].idx != 2'b00)
                    && (!r_obj[0].prio || (w_bgi == 2'b00));
    assign w_opal = r_obj[0].pal ? obp1 : obp0;
    assign w_osh  = w_opal >> {r_obj[0].idx, 1'b0};
    assign w_bsh  = bgp >> {w_bgi, 1'b0};

    assign color     = w_osel ? w_osh[1:0] : w_bsh[1:0];
    assign pix_valid = w_valid;
    assign bg_ready  = w_ready;
    assign count     = r_count;
    assign ovf       = r_ovf;

endmodule
